// File: rtl/wb_port_sequencer.sv
// Serializes the E and M write-back destinations of one request onto a single
// register-file write port, E first, then M.
module wb_port_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  dstE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic        rf_we,
  output logic [3:0]  rf_addr,
  output logic [63:0] rf_data,
  output logic        busy,
  output logic [15:0] wr_count
);

  localparam logic [3:0] NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    WR_E,
    WR_M
  } state_t;

  state_t      state;
  logic [3:0]  cap_dste;
  logic [3:0]  cap_dstm;
  logic [63:0] cap_vale;
  logic [63:0] cap_valm;

  // WR_E/WR_M are only entered for a real destination, so rf_we never pairs with NONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_dste <= 4'h0;
      cap_dstm <= 4'h0;
      cap_vale <= 64'h0;
      cap_valm <= 64'h0;
      wr_count <= 16'h0;
    end else begin
      if (rf_we)
        wr_count <= wr_count + 16'd1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_dste <= dstE;
            cap_dstm <= dstM;
            cap_vale <= valE;
            cap_valm <= valM;
            if (dstE != NONE)
              state <= WR_E;
            else if (dstM != NONE)
              state <= WR_M;
          end
        end
        WR_E:    state <= (cap_dstm != NONE) ? WR_M : IDLE;
        WR_M:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come only from state and captured registers, so reset drops them at once.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = NONE;
    rf_data = 64'h0;
    case (state)
      WR_E: begin
        rf_we   = 1'b1;
        rf_addr = cap_dste;
        rf_data = cap_vale;
      end
      WR_M: begin
        rf_we   = 1'b1;
        rf_addr = cap_dstm;
        rf_data = cap_valm;
      end
      default: begin
        rf_we   = 1'b0;
        rf_addr = NONE;
        rf_data = 64'h0;
      end
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Bench for wb_port_sequencer: directed scenarios plus random traffic, all
// checked against a queue-of-pending-writes reference model.
module tb_wb_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [63:0] rf_data;
  logic        busy;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         pend[$];
  int unsigned modelCount = 0;

  wb_port_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dstE     (dstE),
    .dstM     (dstM),
    .valE     (valE),
    .valM     (valM),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every output against the pending-write queue of the model.
  task automatic checkAll();
    bit has = (pend.size() != 0);
    checkOutput("rf_we",    64'(rf_we),    64'(has));
    checkOutput("rf_addr",  64'(rf_addr),  has ? 64'(pend[0].addr) : 64'hF);
    checkOutput("rf_data",  rf_data,       has ? pend[0].data : 64'h0);
    checkOutput("in_ready", 64'(in_ready), 64'(!has));
    checkOutput("busy",     64'(busy),     64'(has));
    checkOutput("wr_count", 64'(wr_count), 64'(modelCount));
  endtask

  // One clock edge of the model: retire the displayed write, then accept if idle.
  task automatic modelEdge();
    bit acc = in_valid && (pend.size() == 0);
    if (pend.size() != 0) begin
      void'(pend.pop_front());
      modelCount = (modelCount + 1) % 65536;
    end
    if (acc) begin
      if (dstE != 4'hF) pend.push_back('{addr: dstE, data: valE});
      if (dstM != 4'hF) pend.push_back('{addr: dstM, data: valM});
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] e, input logic [3:0] m,
                               input logic [63:0] ve, input logic [63:0] vm);
    in_valid = v;
    dstE     = e;
    dstM     = m;
    valE     = ve;
    valM     = vm;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'h0, 4'h0, 64'h0, 64'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dstE     = 4'h0;
    dstM     = 4'h0;
    valE     = 64'h0;
    valM     = 64'h0;
    #3;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Single E write, accepted on the first edge after reset release.
    applyStimulus(1'b1, 4'h3, 4'hF, 64'h11, 64'h0);
    checkOutput("t1_addr", 64'(rf_addr), 64'h3);
    checkOutput("t1_data", rf_data, 64'h11);
    idleCycle();
    checkOutput("t1_count", 64'(wr_count), 64'd1);

    // Same destination twice: E then M, ready low for exactly two cycles.
    applyStimulus(1'b1, 4'h4, 4'h4, 64'h100, 64'h200);
    checkOutput("t2_first", rf_data, 64'h100);
    idleCycle();
    checkOutput("t2_second", rf_data, 64'h200);
    checkOutput("t2_notready", 64'(in_ready), 64'h0);
    idleCycle();
    checkOutput("t2_ready", 64'(in_ready), 64'h1);
    checkOutput("t2_count", 64'(wr_count), 64'd3);

    // No destinations: back-to-back accepts, no writes.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 4'hF, 4'hF, 64'(i), 64'(i + 7));
    checkOutput("t3_count", 64'(wr_count), 64'd3);

    // M-only request skips WR_E.
    applyStimulus(1'b1, 4'hF, 4'h7, 64'h55, 64'hAB);
    checkOutput("t4_addr", 64'(rf_addr), 64'h7);
    checkOutput("t4_data", rf_data, 64'hAB);
    idleCycle();

    // in_valid held high with changing data while busy.
    applyStimulus(1'b1, 4'h2, 4'h5, 64'hA0, 64'hB0);
    applyStimulus(1'b1, 4'h9, 4'hA, 64'hDEAD, 64'hBEEF);
    applyStimulus(1'b1, 4'hC, 4'hD, 64'hC0FFEE, 64'hF00D);
    applyStimulus(1'b1, 4'h1, 4'hF, 64'h77, 64'h0);
    checkOutput("t5_reaccept", rf_data, 64'h77);
    idleCycle();

    // Reset during WR_E aborts the sequence asynchronously.
    applyStimulus(1'b1, 4'h6, 4'h8, 64'h66, 64'h88);
    #2;
    rst_n = 1'b0;
    pend.delete();
    modelCount = 0;
    #1;
    checkOutput("t6_we_async", 64'(rf_we), 64'h0);
    checkOutput("t6_count", 64'(wr_count), 64'h0);
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();
    idleCycle();

    // Wrap of wr_count from FFFF to 0000.
    @(negedge clk);
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    modelCount = 16'hFFFE;
    applyStimulus(1'b1, 4'h9, 4'hF, 64'h99, 64'h0);
    idleCycle();
    checkOutput("wrap_ffff", 64'(wr_count), 64'hFFFF);
    applyStimulus(1'b1, 4'hF, 4'h2, 64'h0, 64'h22);
    idleCycle();
    checkOutput("wrap_zero", 64'(wr_count), 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] e;
      logic [3:0] m;
      e = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      m = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      applyStimulus(1'($urandom_range(0, 3) != 0), e, m,
                    {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_sequencer.md
WB_PORT_SEQUENCER -- requirements
Module: wb_port_sequencer

Interface
REQ-001 The block SHALL use a single clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  write-back request present
- in_ready  out  1  block can accept a request
- dstE  in  4  E-port destination register; 4'hF = none
- dstM  in  4  M-port destination register; 4'hF = none
- valE  in  64  E-port write data
- valM  in  64  M-port write data
- rf_we  out  1  register-file write enable, single port
- rf_addr  out  4  register-file write address
- rf_data  out  64  register-file write data
- busy  out  1  sequence in progress
- wr_count  out  16  count of issued register-file writes

Function
REQ-003 The block SHALL serialize the two write-back destinations (E, M) onto one register-file write port.
REQ-004 A request SHALL be accepted only on a rising clk edge where in_valid=1 and in_ready=1; dstE, dstM, valE and valM SHALL be captured into internal registers on that edge only.
REQ-005 in_valid while in_ready=0 SHALL be ignored; inputs need not be held after acceptance.
REQ-006 FSM states: IDLE, WR_E, WR_M; in_ready=1 only in IDLE; busy=1 in WR_E and WR_M.
REQ-007 IDLE on accept: next state WR_E if dstE!=4'hF, else WR_M if dstM!=4'hF, else IDLE; no write is issued when both are 4'hF.
REQ-008 WR_E: rf_we=1, rf_addr=captured dstE, rf_data=captured valE; next state WR_M if captured dstM!=4'hF, else IDLE.
REQ-009 WR_M: rf_we=1, rf_addr=captured dstM, rf_data=captured valM; next state IDLE.
REQ-010 In IDLE, rf_we=0, rf_addr=4'hF and rf_data=64'h0.
REQ-011 Latency: the first write SHALL occur in the cycle immediately after the accept edge; the second write, if any, SHALL occur in the following cycle.
REQ-012 A request therefore occupies 1 to 3 cycles including the accept cycle; maximum throughput is one request per 3 cycles with two writes, per 2 cycles with one, and per cycle with none.
REQ-013 If dstE==dstM!=4'hF, both writes SHALL be issued, E first then M, so the M data is the final register value (popq %rsp semantics).
REQ-014 The block SHALL never issue rf_we=1 with rf_addr=4'hF.
REQ-015 wr_count SHALL increment by 1 on every clk edge where rf_we=1, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-016 rf_we, rf_addr, rf_data, busy and in_ready SHALL be decoded from the FSM state and the captured registers only, with no combinational path from any input.

Reset
REQ-017 While rst_n=0, the block SHALL be in IDLE with rf_we=0, rf_addr=4'hF, rf_data=0, busy=0, in_ready=1, wr_count=0, and all captured registers 0.
REQ-018 Reset asserted mid-sequence (WR_E or WR_M) SHALL abort immediately: the pending write(s) are discarded and rf_we falls asynchronously.
REQ-019 After rst_n deasserts, the first accept SHALL be possible on the first rising clk edge.

Verification
REQ-020 Test 1: accept dstE=3, dstM=F, valE=0x11 -> next cycle rf_we=1, rf_addr=3, rf_data=0x11; then IDLE; wr_count=1.
REQ-021 Test 2: accept dstE=4, dstM=4, valE=0x100, valM=0x200 -> cycle+1 writes addr 4 with 0x100; cycle+2 writes addr 4 with 0x200; wr_count=2; in_ready=0 for exactly 2 cycles.
REQ-022 Test 3: accept dstE=F, dstM=F -> rf_we stays 0, in_ready stays 1, wr_count unchanged; back-to-back accepts succeed every cycle.
REQ-023 Test 4: accept dstE=F, dstM=7, valM=0xAB -> single write to addr 7 with 0xAB on the next cycle; WR_E is skipped.
REQ-024 Test 5: hold in_valid=1 with changing data during WR_E/WR_M -> the changing data is ignored; the next accept occurs only on return to IDLE.
REQ-025 Test 6: assert rst_n=0 during WR_E of a two-write request -> rf_we=0 immediately, no WR_M write, wr_count=0, and in_ready=1 after release; also preload wr_count=0xFFFF via writes, then one write -> 0x0000.
